// File: rtl/ifu_prefetch_pkg.sv
// Shared types and constants for the instruction prefetch stage (ifu_prefetch, ifq_fifo).
package ifu_prefetch_pkg;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        IFU_BOOT  = 2'd0,
        IFU_RUN   = 2'd1,
        IFU_DRAIN = 2'd2
    } ifu_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_prefetch_ifq_fifo.sv
// ifq_fifo: DEPTH x 64-bit synchronous FIFO of {pc,inst} with clear; clear beats write/read.
module ifq_fifo
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       wr_en,
    input  logic [63:0]                wr_data,
    input  logic                       rd_en,
    output logic [63:0]                rd_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    ifq_entry_t    mem_q [DEPTH];
    ifq_entry_t    mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_rd, do_wr;

    always_comb begin
        do_rd   = rd_en && (count_q != '0);
        do_wr   = wr_en && ((count_q != FULL_C) || do_rd);
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (do_wr) begin
                mem_d[wptr_q] = ifq_entry_t'(wr_data);
                wptr_d        = wptr_q + AW'(1);
            end
            if (do_rd) begin
                rptr_d = rptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_wr) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign rd_data = mem_q[rptr_q];
    assign count   = count_q;

endmodule

// File: rtl/ifu_prefetch.sv
// Instruction prefetch: credit-limited in-order fetch, PC-tagged return queue, redirect flush.
// Optional FETCH_PERF_CNT_EN adds the stall_cnt output (empty-but-ready cycle counter).
module ifu_prefetch
    import ifu_prefetch_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_inst,
    output logic [31:0] out_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW+1)'(DEPTH);

    ifu_state_e    state_q, state_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] discard_q, discard_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   tag_q [DEPTH];
    logic [31:0]   tag_d [DEPTH];
    logic [AW-1:0] tag_wp_q, tag_wp_d;
    logic [AW-1:0] tag_rp_q, tag_rp_d;

    logic [CW-1:0] q_count;
    logic [63:0]   q_rd_data;
    logic [63:0]   q_wr_data;
    ifq_entry_t    head;
    logic          issue, drop, q_wr, q_rd;
    logic [CW:0]   credit_used;

    always_comb begin
        state_d       = state_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        addr_d        = addr_q;
        tag_d         = tag_q;
        tag_wp_d      = tag_wp_q;
        tag_rp_d      = tag_rp_q;

        // Queued plus in-flight words may never exceed DEPTH, so a return always finds room.
        credit_used = {1'b0, q_count} + {1'b0, outstanding_q};
        imem_req    = (state_q == IFU_RUN) && !redirect_valid && (credit_used < DEPTH_C);
        issue       = imem_req && imem_gnt;
        drop        = imem_rvalid && (discard_q != '0);
        q_wr        = imem_rvalid && !drop && !redirect_valid;
        q_rd        = out_ready && (q_count != '0);
        q_wr_data   = {tag_q[tag_rp_q], imem_rdata};

        if (issue) begin
            tag_d[tag_wp_q] = addr_q;
            tag_wp_d        = tag_wp_q + AW'(1);
            addr_d          = addr_q + 32'd4;
        end
        // Tags retire on every return, including dropped ones, to stay aligned with the memory.
        if (imem_rvalid) begin
            tag_rp_d = tag_rp_q + AW'(1);
        end
        outstanding_d = outstanding_q + CW'(issue) - CW'(imem_rvalid);
        if (drop) begin
            discard_d = discard_q - CW'(1);
        end

        case (state_q)
            IFU_BOOT:  state_d = IFU_RUN;
            IFU_RUN:   if (redirect_valid && (outstanding_d != '0)) state_d = IFU_DRAIN;
            IFU_DRAIN: if (discard_d == '0) state_d = IFU_RUN;
            default:   state_d = IFU_BOOT;
        endcase

        if (redirect_valid) begin
            addr_d = word_align(redirect_pc);
            if (state_q != IFU_DRAIN) begin
                discard_d = outstanding_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= IFU_BOOT;
            outstanding_q <= '0;
            discard_q     <= '0;
            addr_q        <= RESET_PC;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
            tag_wp_q      <= '0;
            tag_rp_q      <= '0;
        end else begin
            state_q       <= state_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            addr_q        <= addr_d;
            tag_q         <= tag_d;
            tag_wp_q      <= tag_wp_d;
            tag_rp_q      <= tag_rp_d;
        end
    end

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_ifq (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (redirect_valid),
        .wr_en   (q_wr),
        .wr_data (q_wr_data),
        .rd_en   (q_rd),
        .rd_data (q_rd_data),
        .count   (q_count)
    );

    assign head      = ifq_entry_t'(q_rd_data);
    assign imem_addr = addr_q;
    assign out_valid = (q_count != '0);
    assign out_inst  = out_valid ? head.inst : '0;
    assign out_pc    = out_valid ? head.pc : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_ready && !out_valid && (state_q != IFU_BOOT) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ifu_prefetch.sv
// Self-checking bench for ifu_prefetch: memory model with latency/grant control and a
// stream-level reference (expected fetch and consume PCs). Honours FETCH_PERF_CNT_EN.
module tb_ifu_prefetch;

    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h0000_3000;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt;
`endif

    ifu_prefetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt      (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        pend[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc, lat, gnt_pct, stale, consumed, grants, exp_stall, first_valid_cyc;
    logic [31:0] exp_pc, exp_fetch, last_gaddr, prev_addr, first_pc;
    bit          prev_wait, prev_redirect, wrap_seen, got_first;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic reset_assert();
        @(negedge clk);
        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
    endtask

    task automatic reset_release();
        repeat (2) @(negedge clk);
        pend.delete();
        cyc = 0; stale = 0; consumed = 0; grants = 0; exp_stall = 0; first_valid_cyc = -1;
        exp_pc = RST_PC; exp_fetch = RST_PC; last_gaddr = '0; prev_addr = '0;
        prev_wait = 1'b0; prev_redirect = 1'b0; wrap_seen = 1'b0; got_first = 1'b0;
        rst = 1'b1;
    endtask

    // One clock cycle: memory model + stream-level checks. Entered and left at a negedge.
    task automatic step(input bit rd_v, input logic [31:0] rd_pc, input bit rdy);
        bit          rv, gn, pop, req_s, vld_s;
        logic [31:0] addr_s;
        redirect_valid = rd_v;
        redirect_pc    = rd_pc;
        out_ready      = rdy;
        rv             = (pend.size() > 0) && (pend[0].due <= cyc);
        imem_rvalid    = rv;
        imem_rdata     = rv ? memfn(pend[0].addr) : $urandom();
        #1;
        gn       = imem_req && ($urandom_range(99) < gnt_pct);
        imem_gnt = gn;
        req_s    = imem_req;
        addr_s   = imem_addr;
        vld_s    = out_valid;
        pop      = out_valid && rdy;
        if (prev_wait && !rd_v) begin
            checks++;
            if (req_s !== 1'b1 || addr_s !== prev_addr) begin
                errors++;
                $display("FAIL req_hold cyc=%0d: got req=%b addr=%h, expected req=1 addr=%h", cyc, req_s, addr_s, prev_addr);
            end
        end
        if (rd_v || stale > 0) begin
            checks++;
            if (req_s !== 1'b0) begin
                errors++;
                $display("FAIL req_blocked cyc=%0d: got req=%b, expected 0 (redirect=%b stale=%0d)", cyc, req_s, rd_v, stale);
            end
        end
        if (prev_redirect) begin
            checks++;
            if (vld_s !== 1'b0) begin
                errors++;
                $display("FAIL valid_after_redirect cyc=%0d: got %b, expected 0", cyc, vld_s);
            end
        end
        if (req_s && gn) begin
            checks++;
            if (addr_s !== exp_fetch) begin
                errors++;
                $display("FAIL fetch_addr cyc=%0d: got %h, expected %h", cyc, addr_s, exp_fetch);
            end
        end
        if (pop) begin
            checks++;
            if (out_pc !== exp_pc || out_inst !== memfn(exp_pc)) begin
                errors++;
                $display("FAIL consume cyc=%0d: got pc=%h inst=%h, expected pc=%h inst=%h", cyc, out_pc, out_inst, exp_pc, memfn(exp_pc));
            end
            if (!got_first) begin
                got_first = 1'b1;
                first_pc  = out_pc;
            end
        end
        if (vld_s && first_valid_cyc < 0) first_valid_cyc = cyc;
        @(posedge clk);
        if (rdy && !vld_s && cyc != 0) exp_stall++;
        if (req_s && gn) begin
            pend.push_back('{addr: addr_s, due: cyc + lat});
            if (addr_s == 32'h0 && last_gaddr == 32'hFFFF_FFFC) wrap_seen = 1'b1;
            last_gaddr = addr_s;
            exp_fetch  = exp_fetch + 32'd4;
            grants++;
        end
        if (rv) begin
            void'(pend.pop_front());
            if (stale > 0) stale--;
        end
        if (pop) begin
            exp_pc = exp_pc + 32'd4;
            consumed++;
        end
        if (rd_v) begin
            exp_pc    = {rd_pc[31:2], 2'b00};
            exp_fetch = {rd_pc[31:2], 2'b00};
            stale     = pend.size();
        end
        checks++;
        if (pend.size() > DEPTH) begin
            errors++;
            $display("FAIL outstanding_max cyc=%0d: got %0d, expected <= %0d", cyc, pend.size(), DEPTH);
        end
        prev_wait     = req_s && !gn;
        prev_addr     = addr_s;
        prev_redirect = rd_v;
        cyc++;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_assert();
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== RST_PC) begin
            errors++;
            $display("FAIL reset_imem: got req=%b addr=%h, expected req=0 addr=%h", imem_req, imem_addr, RST_PC);
        end
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_out: got valid=%b inst=%h pc=%h, expected 0/0/0", out_valid, out_inst, out_pc);
        end
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'h0) begin
            errors++;
            $display("FAIL reset_stall: got %h, expected 0", stall_cnt);
        end
`endif
        reset_release();
    endtask

    task automatic test_stream();
        int gaps = 0;
        reset_assert(); reset_release();
        lat = 1; gnt_pct = 100;
        for (int i = 0; i < 40; i++) begin
            if (first_valid_cyc >= 0 && !out_valid) gaps++;
            step(1'b0, '0, 1'b1);
        end
        checks++;
        if (first_valid_cyc != 3) begin
            errors++;
            $display("FAIL first_valid: got cycle %0d, expected 3", first_valid_cyc);
        end
        checks++;
        if (gaps != 0 || consumed != 37) begin
            errors++;
            $display("FAIL stream_gaps: got gaps=%0d consumed=%0d, expected 0/37", gaps, consumed);
        end
    endtask

    task automatic test_backpressure();
        reset_assert(); reset_release();
        lat = 1; gnt_pct = 100;
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b0);
        checks++;
        if (grants != DEPTH || imem_req !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_stop: got grants=%0d req=%b valid=%b, expected %0d/0/1", grants, imem_req, out_valid, DEPTH);
        end
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (consumed < 15) begin
            errors++;
            $display("FAIL resume: got consumed=%0d, expected >= 15", consumed);
        end
    endtask

    task automatic test_random_latency();
        reset_assert(); reset_release();
        lat = 5; gnt_pct = 60;
        for (int i = 0; i < 300; i++) step(1'b0, '0, ($urandom_range(99) < 70));
        checks++;
        if (consumed < 20) begin
            errors++;
            $display("FAIL rand_progress: got consumed=%0d, expected >= 20", consumed);
        end
        lat = 3; gnt_pct = 75;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 4) step(1'b1, $urandom(), ($urandom_range(99) < 80));
            else                        step(1'b0, '0, ($urandom_range(99) < 80));
        end
    endtask

    task automatic test_redirect_drain();
        int n = 0;
        reset_assert(); reset_release();
        lat = 5; gnt_pct = 100;
        while (pend.size() != 3 && n < 10) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        step(1'b1, 32'h0000_4002, 1'b1);
        checks++;
        if (stale != 3) begin
            errors++;
            $display("FAIL drain_setup: got in_flight=%0d, expected 3", stale);
        end
        got_first = 1'b0;
        for (int i = 0; i < 30; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (!got_first || first_pc !== 32'h0000_4000) begin
            errors++;
            $display("FAIL drain_first_pc: got seen=%b pc=%h, expected seen=1 pc=00004000", got_first, first_pc);
        end
    endtask

    task automatic test_redirect_pop();
        int  n = 0;
        bit  hit = 1'b0;
        reset_assert(); reset_release();
        lat = 1; gnt_pct = 100;
        while (!hit && n < 30) begin
            if (out_valid && pend.size() > 0 && pend[0].due <= cyc) begin
                step(1'b1, 32'h0000_5000, 1'b1);
                hit = 1'b1;
            end else begin
                step(1'b0, '0, 1'b1);
            end
            n++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL pop_redirect_setup: got no pop+rvalid cycle, expected one within 30");
        end
        got_first = 1'b0;
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (!got_first || first_pc !== 32'h0000_5000) begin
            errors++;
            $display("FAIL pop_redirect_pc: got seen=%b pc=%h, expected seen=1 pc=00005000", got_first, first_pc);
        end
    endtask

    task automatic test_wrap();
        reset_assert(); reset_release();
        lat = 1; gnt_pct = 100;
        for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
        step(1'b1, 32'hFFFF_FFF5, 1'b1);
        got_first = 1'b0;
        for (int i = 0; i < 20; i++) step(1'b0, '0, 1'b1);
        checks++;
        if (!wrap_seen || first_pc !== 32'hFFFF_FFF4) begin
            errors++;
            $display("FAIL addr_wrap: got wrap=%b first=%h, expected wrap=1 first=fffffff4", wrap_seen, first_pc);
        end
    endtask

    task automatic test_stall();
        reset_assert(); reset_release();
        lat = 1; gnt_pct = 0;
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1);
        gnt_pct = 100;
        for (int i = 0; i < 30; i++) step(1'b0, '0, i[0]);
        gnt_pct = 40;
        for (int i = 0; i < 30; i++) step(1'b0, '0, ($urandom_range(99) < 60));
`ifdef FETCH_PERF_CNT_EN
        checks++;
        if (stall_cnt !== 32'(exp_stall)) begin
            errors++;
            $display("FAIL stall_cnt: got %0d, expected %0d", stall_cnt, exp_stall);
        end
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by 400000, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_random_latency();
        test_redirect_drain();
        test_redirect_pop();
        test_wrap();
        test_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
